axis_pkt_arbiter2: RTL and testbench
====================================

Name: axis_pkt_arbiter2

Overview:
- Packet-granular round-robin arbiter that merges two AXI-Stream sources into one 32-bit stream feeding the FNV-1a tap/hash stage.
- A grant is held from the first beat of a packet through its tlast beat, so the downstream hash never sees interleaved packets.
- Per-packet status (source, length) is registered so software can pair each hash with its producer.

Parameters:
- LEN_W, 16, width of the per-packet beat counter and of last_pkt_len; the counter saturates at all-ones.
- RR_INIT, 1'b1, initial value of last_grant after reset; the default gives src0 priority on the first contention.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous assert, active-low
- arb_en  in  1  when low, no new grant is issued; a packet already in flight completes
- s0_axis_tdata  in  32  source 0 data
- s0_axis_tvalid  in  1  source 0 valid
- s0_axis_tready  out  1  source 0 ready
- s0_axis_tlast  in  1  source 0 end of packet
- s1_axis_tdata / s1_axis_tvalid / s1_axis_tready / s1_axis_tlast  same as source 0, for source 1
- m_axis_tdata  out  32  merged data
- m_axis_tvalid  out  1  merged valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  merged end of packet
- m_axis_tid  out  1  index of the granted source
- busy  out  1  high while in GRANT0 or GRANT1
- last_pkt_src  out  1  source of the most recently completed packet
- last_pkt_len  out  LEN_W  beat count of the most recently completed packet

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - state=IDLE, last_grant=RR_INIT, beat_cnt=0, last_pkt_src=0, last_pkt_len=0.
  - All readies and m_axis_tvalid are 0.
- State machine has three states: IDLE, GRANT0, GRANT1.
- Arbitration in IDLE:
  - Only src0 valid → GRANT0. Only src1 valid → GRANT1.
  - Both valid → grant the source that is NOT last_grant.
  - Neither valid, or arb_en=0 → stay in IDLE.
  - On every grant, update last_grant to the granted source.
- In IDLE: all tready=0, m_axis_tvalid=0, m_axis_tid holds last_grant.
- In GRANTn: combinational pass-through with zero latency:
  - m_axis_* = sn_axis_*
  - sn_axis_tready = m_axis_tready
  - the other source's tready = 0
  - m_axis_tid = n
- A beat is m_axis_tvalid && m_axis_tready.
  - Each beat increments beat_cnt, saturating at 2^LEN_W−1.
- On a beat with tlast:
  - last_pkt_len = beat_cnt + 1 (saturating), last_pkt_src = n.
  - beat_cnt clears; next state is IDLE.
- Throughput: exactly one idle bubble cycle between packets. The maximum rate is an L-beat packet every L+1 cycles.
- A source that drops tvalid mid-packet keeps the grant; the arbiter waits indefinitely.
- arb_en deasserted mid-packet has no effect until the tlast beat; the block then stays in IDLE.
- Single-beat packet (tlast on the first beat): last_pkt_len=1 and the block returns to IDLE.
- tvalid that rises while in IDLE is sampled the same cycle; the grant takes effect the next cycle.
- Reset asserted mid-packet: the block returns immediately to IDLE and no status is updated. Upstream is responsible for flushing partial packets.

Optional Feature:
- Macro: AXIS_ARB_STATS_EN.
- With the macro defined, add outputs pkt_cnt0[31:0] and pkt_cnt1[31:0]:
  - Each counts tlast beats from its source, wraps modulo 2^32, and resets to 0.
  - Also add output contention_cnt[31:0]: increments on each IDLE cycle where both sources are valid and arb_en=1.
- Without the macro, these ports and registers do not exist.

Decomposition:
- Shared package/include holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT0=2'd1, ST_GRANT1=2'd2
  - AXIS_DATA_W=32
  - SRC_ID_W=1
- The round-robin pick is natural as a sub-module, axis_rr_pick2. It is combinational: inputs req[1:0] and last_grant; outputs gnt_valid and gnt_id.
- FSM, mux, and counters stay in the top level.

Test Plan:
- Contention: after reset, both sources hold a 3-beat packet valid (s0: 0x10,0x11,0x12; s1: 0x20,0x21,0x22), m_axis_tready=1.
  - Output is 0x10,0x11,0x12 with tid=0, one bubble, then 0x20,0x21,0x22 with tid=1.
  - last_pkt_len=3 and last_pkt_src=1 at the end.
- Single source: only s1 sends four 1-beat packets.
  - Every packet is granted to s1, with one bubble between packets.
  - last_pkt_len=1 after each.
- Backpressure: s0 sends a 4-beat packet while m_axis_tready toggles 1,0,0,1,...
  - s1 tready stays 0 throughout.
  - Data arrives in order with no duplicates; last_pkt_len=4.
- Stall mid-packet: s0 drops tvalid for 5 cycles after beat 2 while s1 is valid.
  - No switch to s1 occurs; s0 completes first.
- arb_en=0 asserted during beat 2 of a 4-beat packet: the packet completes, busy falls, and the block stays IDLE until arb_en=1.
- Reset asserted mid-packet (beat 2 of 5): outputs return to reset values asynchronously, and last_pkt_len keeps no partial value (stays 0).
- With AXIS_ARB_STATS_EN defined, the contention scenario additionally yields pkt_cnt0=1, pkt_cnt1=1, contention_cnt=1.

Source files
------------

// File: rtl/axis_pkt_arbiter2_pkg.sv
// Shared definitions for the two-source AXI-Stream packet arbiter.
package axis_pkt_arbiter2_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned SRC_ID_W    = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/axis_pkt_arbiter2_rr_pick.sv
// axis_rr_pick2: combinational two-way round-robin pick; on contention the
// source that was not granted last wins.
module axis_rr_pick2
  import axis_pkt_arbiter2_pkg::*;
(
  input  logic [1:0]          req,
  input  logic [SRC_ID_W-1:0] last_grant,
  output logic                gnt_valid,
  output logic [SRC_ID_W-1:0] gnt_id
);

  always_comb begin
    gnt_valid = |req;
    if (&req) gnt_id = ~last_grant;
    else      gnt_id = req[1];
  end

endmodule

// File: rtl/axis_pkt_arbiter2.sv
// Packet-granular round-robin merge of two AXI-Stream sources.
// Optional statistics counters are built when AXIS_ARB_STATS_EN is defined.
module axis_pkt_arbiter2
  import axis_pkt_arbiter2_pkg::*;
#(
  parameter int unsigned LEN_W   = 16,
  parameter logic        RR_INIT = 1'b1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   arb_en,
  input  logic [AXIS_DATA_W-1:0] s0_axis_tdata,
  input  logic                   s0_axis_tvalid,
  output logic                   s0_axis_tready,
  input  logic                   s0_axis_tlast,
  input  logic [AXIS_DATA_W-1:0] s1_axis_tdata,
  input  logic                   s1_axis_tvalid,
  output logic                   s1_axis_tready,
  input  logic                   s1_axis_tlast,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [SRC_ID_W-1:0]    m_axis_tid,
  output logic                   busy,
  output logic [SRC_ID_W-1:0]    last_pkt_src,
  output logic [LEN_W-1:0]       last_pkt_len
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [31:0]            pkt_cnt0,
  output logic [31:0]            pkt_cnt1,
  output logic [31:0]            contention_cnt
`endif
);

  arb_state_t          state, state_nxt;
  logic [SRC_ID_W-1:0] last_grant;
  logic [LEN_W-1:0]    beat_cnt;
  logic [LEN_W-1:0]    beat_inc;
  logic                gnt_valid;
  logic [SRC_ID_W-1:0] gnt_id;
  logic                take_grant;
  logic                beat;

  axis_rr_pick2 u_pick (
    .req        ({s1_axis_tvalid, s0_axis_tvalid}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    state_nxt      = state;
    m_axis_tdata   = '0;
    m_axis_tvalid  = 1'b0;
    m_axis_tlast   = 1'b0;
    m_axis_tid     = last_grant;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    take_grant     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_en && gnt_valid) begin
          take_grant = 1'b1;
          state_nxt  = (gnt_id == '0) ? ST_GRANT0 : ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tlast   = s0_axis_tlast;
        m_axis_tid     = '0;
        s0_axis_tready = m_axis_tready;
      end
      ST_GRANT1: begin
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tlast   = s1_axis_tlast;
        m_axis_tid     = SRC_ID_W'(1);
        s1_axis_tready = m_axis_tready;
      end
      default: state_nxt = ST_IDLE;
    endcase
    beat = m_axis_tvalid && m_axis_tready;
    if (beat && m_axis_tlast) state_nxt = ST_IDLE;
  end

  assign busy     = (state == ST_GRANT0) || (state == ST_GRANT1);
  assign beat_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + LEN_W'(1);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      last_grant <= RR_INIT;
    end else begin
      state <= state_nxt;
      if (take_grant) last_grant <= gnt_id;
    end
  end

  // Status is written only on the closing beat, so a reset mid-packet leaves no partial length.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt     <= '0;
      last_pkt_src <= '0;
      last_pkt_len <= '0;
    end else if (beat) begin
      if (m_axis_tlast) begin
        beat_cnt     <= '0;
        last_pkt_len <= beat_inc;
        last_pkt_src <= m_axis_tid;
      end else begin
        beat_cnt <= beat_inc;
      end
    end
  end

`ifdef AXIS_ARB_STATS_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt0       <= '0;
      pkt_cnt1       <= '0;
      contention_cnt <= '0;
    end else begin
      if (beat && m_axis_tlast && (state == ST_GRANT0)) pkt_cnt0 <= pkt_cnt0 + 32'd1;
      if (beat && m_axis_tlast && (state == ST_GRANT1)) pkt_cnt1 <= pkt_cnt1 + 32'd1;
      if ((state == ST_IDLE) && arb_en && s0_axis_tvalid && s1_axis_tvalid)
        contention_cnt <= contention_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter2.sv
// Scoreboard bench for axis_pkt_arbiter2: per-source expected beat queues,
// a packet-level arbitration model and directed plus randomized traffic.
module tb_axis_pkt_arbiter2;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        arb_en;
  logic [31:0] s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
  logic        s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic        s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        m_axis_tid;
  logic        busy;
  logic        last_pkt_src;
  logic [15:0] last_pkt_len;
`ifdef AXIS_ARB_STATS_EN
  logic [31:0] pkt_cnt0, pkt_cnt1, contention_cnt;
`endif

  always #5 aclk = ~aclk;

  axis_pkt_arbiter2 #(.LEN_W(16), .RR_INIT(1'b1)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .arb_en         (arb_en),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tready (s0_axis_tready),
    .s0_axis_tlast  (s0_axis_tlast),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tready (s1_axis_tready),
    .s1_axis_tlast  (s1_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tid     (m_axis_tid),
    .busy           (busy),
    .last_pkt_src   (last_pkt_src),
    .last_pkt_len   (last_pkt_len)
`ifdef AXIS_ARB_STATS_EN
    ,
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1),
    .contention_cnt (contention_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [32:0] obs_q[$];

  bit   mon_en = 0;
  bit   grant_pend = 0, idle_pend = 0, stat_pend = 0;
  logic mdl_last = 1'b1;
  logic exp_gid, cur_tid;
  int   stat_src, stat_len, mon_len = 0;
  int   rdy_mode = 0, arb_mode = 0, rdy_cnt = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge aclk) begin
    #1;
    rdy_cnt++;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (rdy_cnt % 3 == 0);
      default: m_axis_tready = ($urandom_range(99) < 70);
    endcase
    case (arb_mode)
      0:       arb_en = 1'b1;
      1:       arb_en = 1'b0;
      default: arb_en = ($urandom_range(99) < 85);
    endcase
  end

  // Monitor: checks last cycle's predictions, then evaluates this cycle.
  always @(negedge aclk) begin
    if (mon_en) begin
      if (grant_pend) begin
        chk(busy && (m_axis_tid == exp_gid), "grant", {busy, m_axis_tid}, {1'b1, exp_gid});
        cur_tid = exp_gid;
        grant_pend = 0;
      end
      if (idle_pend) begin
        chk(!busy, "hold_idle", busy, 0);
        idle_pend = 0;
      end
      if (stat_pend) begin
        chk(last_pkt_src == stat_src[0], "last_pkt_src", last_pkt_src, stat_src);
        chk(last_pkt_len == stat_len[15:0], "last_pkt_len", last_pkt_len, stat_len);
        chk(!busy, "bubble", busy, 0);
        stat_pend = 0;
      end
      if (!busy) begin
        chk(!m_axis_tvalid && !s0_axis_tready && !s1_axis_tready && (m_axis_tid == mdl_last),
            "idle_outputs", {m_axis_tvalid, s0_axis_tready, s1_axis_tready, m_axis_tid},
            {3'b000, mdl_last});
        if (arb_en && (s0_axis_tvalid || s1_axis_tvalid)) begin
          if (s0_axis_tvalid && s1_axis_tvalid) exp_gid = ~mdl_last;
          else                                  exp_gid = s1_axis_tvalid;
          mdl_last = exp_gid;
          grant_pend = 1;
        end else begin
          idle_pend = 1;
        end
      end else begin
        chk(m_axis_tid == cur_tid, "tid_hold", m_axis_tid, cur_tid);
        if (cur_tid)
          chk((s1_axis_tready == m_axis_tready) && !s0_axis_tready, "ready_route1",
              {s1_axis_tready, s0_axis_tready}, {m_axis_tready, 1'b0});
        else
          chk((s0_axis_tready == m_axis_tready) && !s1_axis_tready, "ready_route0",
              {s0_axis_tready, s1_axis_tready}, {m_axis_tready, 1'b0});
        if (m_axis_tvalid && m_axis_tready) begin
          logic [32:0] e;
          bit          have;
          have = cur_tid ? (q1.size() != 0) : (q0.size() != 0);
          if (!have) begin
            chk(0, "unexpected_beat", {m_axis_tlast, m_axis_tdata}, 0);
          end else begin
            e = cur_tid ? q1.pop_front() : q0.pop_front();
            chk({m_axis_tlast, m_axis_tdata} == e, "beat_data", {m_axis_tlast, m_axis_tdata}, e);
          end
          obs_q.push_back({cur_tid, m_axis_tdata});
          mon_len++;
          if (m_axis_tlast) begin
            stat_src = int'(cur_tid);
            stat_len = mon_len;
            stat_pend = 1;
            mon_len = 0;
          end
        end
      end
    end
  end

  task automatic set_src(input int src, input logic v, input logic [31:0] d, input logic l);
    if (src == 0) begin s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tlast = l; end
    else          begin s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tlast = l; end
  endtask

  // Called at posedge+1; returns at posedge+1 after the final handshake.
  task automatic send_pkt(input int src, input int len, input logic [31:0] base,
                          input int gap_pct, input int stall_at, input int stall_len);
    for (int i = 0; i < len; i++) begin
      bit hs;
      int waited;
      if (i == stall_at)
        repeat (stall_len) begin set_src(src, 1'b0, '0, 1'b0); @(posedge aclk); #1; end
      while ($urandom_range(99) < gap_pct) begin
        set_src(src, 1'b0, '0, 1'b0); @(posedge aclk); #1;
      end
      set_src(src, 1'b1, base + i, (i == len - 1));
      if (src == 0) q0.push_back({(i == len - 1), base + i});
      else          q1.push_back({(i == len - 1), base + i});
      hs = 0;
      waited = 0;
      while (!hs) begin
        @(negedge aclk);
        hs = (src == 0) ? (s0_axis_tvalid && s0_axis_tready) : (s1_axis_tvalid && s1_axis_tready);
        @(posedge aclk); #1;
        waited++;
        if (!hs && waited > 3000) begin
          chk(0, "handshake_timeout", src, waited);
          hs = 1;
        end
      end
    end
    set_src(src, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_obs(input int n);
    int t = 0;
    while (obs_q.size() < n && t < 3000) begin @(negedge aclk); t++; end
    if (obs_q.size() < n) chk(0, "obs_timeout", obs_q.size(), n);
  endtask

  task automatic chk_obs(input int idx, input logic tid, input logic [31:0] d, input string name);
    logic [32:0] got;
    got = (idx < obs_q.size()) ? obs_q[idx] : 33'h1_ffff_ffff;
    chk(got == {tid, d}, name, got, {tid, d});
  endtask

  initial begin
    int n0;
    aresetn = 1'b0;
    s0_axis_tvalid = 0; s0_axis_tdata = '0; s0_axis_tlast = 0;
    s1_axis_tvalid = 0; s1_axis_tdata = '0; s1_axis_tlast = 0;
    m_axis_tready = 1'b1; arb_en = 1'b1;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    chk(!busy && !m_axis_tvalid && !s0_axis_tready && !s1_axis_tready, "reset_outputs",
        {busy, m_axis_tvalid, s0_axis_tready, s1_axis_tready}, 0);
    chk(last_pkt_len == 0 && last_pkt_src == 0, "reset_status", {last_pkt_src, last_pkt_len}, 0);
    chk(m_axis_tid == 1'b1, "reset_tid", m_axis_tid, 1);
    mon_en = 1;
    @(posedge aclk); #1;

    // Contention: src0 wins first, then src1 after one bubble.
    n0 = obs_q.size();
    fork
      send_pkt(0, 3, 32'h10, 0, -1, 0);
      send_pkt(1, 3, 32'h20, 0, -1, 0);
    join
    for (int k = 0; k < 3; k++) begin
      chk_obs(n0 + k, 1'b0, 32'h10 + k, "contention_s0");
      chk_obs(n0 + 3 + k, 1'b1, 32'h20 + k, "contention_s1");
    end
    @(negedge aclk);
    chk(last_pkt_len == 3 && last_pkt_src == 1'b1, "contention_status", {last_pkt_src, last_pkt_len}, {1'b1, 16'd3});
`ifdef AXIS_ARB_STATS_EN
    chk(pkt_cnt0 == 1 && pkt_cnt1 == 1 && contention_cnt == 1, "stats",
        {pkt_cnt0[15:0], pkt_cnt1[15:0], contention_cnt[15:0]}, {16'd1, 16'd1, 16'd1});
`endif
    @(posedge aclk); #1;

    // Single source, single-beat packets.
    for (int k = 0; k < 4; k++) begin
      send_pkt(1, 1, 32'h30 + k, 0, -1, 0);
      @(negedge aclk);
      chk(last_pkt_len == 1 && last_pkt_src == 1'b1, "single_beat", {last_pkt_src, last_pkt_len}, {1'b1, 16'd1});
      @(posedge aclk); #1;
    end

    // Backpressure pattern on the master side.
    rdy_mode = 1;
    send_pkt(0, 4, 32'h40, 0, -1, 0);
    @(negedge aclk);
    chk(last_pkt_len == 4, "backpressure_len", last_pkt_len, 4);
    @(posedge aclk); #1;
    rdy_mode = 0;

    // Stall mid-packet with the other source waiting.
    n0 = obs_q.size();
    fork
      send_pkt(0, 4, 32'h50, 0, 2, 5);
      begin @(posedge aclk); #1; send_pkt(1, 2, 32'h60, 0, -1, 0); end
    join
    for (int k = 0; k < 4; k++) chk_obs(n0 + k, 1'b0, 32'h50 + k, "stall_order");
    chk_obs(n0 + 4, 1'b1, 32'h60, "stall_then_s1");

    // arb_en dropped during beat 2: packet completes, block then holds IDLE.
    @(posedge aclk); #1;
    n0 = obs_q.size();
    fork
      send_pkt(0, 4, 32'h70, 0, -1, 0);
      begin
        wait_obs(n0 + 1);
        @(posedge aclk); #1 arb_mode = 1;
        wait_obs(n0 + 4);
        repeat (6) @(posedge aclk);
        @(negedge aclk);
        chk(!busy, "arb_off_idle", busy, 0);
        @(posedge aclk); #1 arb_mode = 0;
      end
      begin wait_obs(n0 + 1); @(posedge aclk); #1; send_pkt(1, 2, 32'h80, 0, -1, 0); end
    join
    chk_obs(n0 + 3, 1'b0, 32'h73, "arb_off_complete");
    chk_obs(n0 + 4, 1'b1, 32'h80, "arb_on_resume");

    // Randomized traffic.
    rdy_mode = 2; arb_mode = 2;
    fork
      for (int k = 0; k < 12; k++) send_pkt(0, $urandom_range(1, 6), 32'h1000 + 16 * k, 30, -1, 0);
      for (int k = 0; k < 12; k++) send_pkt(1, $urandom_range(1, 6), 32'h2000 + 16 * k, 30, -1, 0);
    join
    rdy_mode = 0; arb_mode = 0;
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    chk(q0.size() == 0 && q1.size() == 0, "drain", {q0.size(), q1.size()}, 0);

    // Reset asserted during beat 2 of a 5-beat packet.
    mon_en = 0;
    @(posedge aclk); #1;
    set_src(0, 1'b1, 32'hA0, 1'b0);
    begin
      int t = 0;
      int got = 0;
      while (got < 2 && t < 100) begin
        @(negedge aclk);
        if (s0_axis_tvalid && s0_axis_tready) got++;
        @(posedge aclk); #1;
        s0_axis_tdata = 32'hA0 + got;
        t++;
      end
    end
    @(negedge aclk); #1 aresetn = 1'b0;
    #1;
    chk(!busy && !m_axis_tvalid && !s0_axis_tready && !s1_axis_tready, "async_reset_outputs",
        {busy, m_axis_tvalid, s0_axis_tready, s1_axis_tready}, 0);
    chk(last_pkt_len == 0 && last_pkt_src == 0, "async_reset_status", {last_pkt_src, last_pkt_len}, 0);
    chk(m_axis_tid == 1'b1, "async_reset_tid", m_axis_tid, 1);
    set_src(0, 1'b0, '0, 1'b0);
    @(posedge aclk); #1 aresetn = 1'b1;
    q0.delete(); q1.delete();
    mdl_last = 1'b1; grant_pend = 0; idle_pend = 0; stat_pend = 0; mon_len = 0;
    mon_en = 1;
    send_pkt(0, 2, 32'hB0, 0, -1, 0);
    @(negedge aclk);
    chk(last_pkt_len == 2 && last_pkt_src == 0, "post_reset_len", {last_pkt_src, last_pkt_len}, {1'b0, 16'd2});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
